// File: rtl/pvt_ro_freq_meter_if.sv
// rtl/pvt_ro_freq_meter_if.sv - control/readout bundle of the ring-oscillator frequency meter
interface pvt_ro_freq_meter_if #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 12,
    parameter int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic [NCH-1:0]    ch_en;
    logic              clear_stats;
    logic [SEL_W-1:0]  rd_sel;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  rd_min;
    logic [CNT_W-1:0]  rd_max;
    logic [NCH-1:0]    ovf;

    modport master (
        output start, gate_cycles, ch_en, clear_stats, rd_sel,
        input  busy, done, rd_count, rd_min, rd_max, ovf
    );

    modport slave (
        input  start, gate_cycles, ch_en, clear_stats, rd_sel,
        output busy, done, rd_count, rd_min, rd_max, ovf
    );
endinterface

// File: rtl/pvt_ro_freq_meter.sv
// rtl/pvt_ro_freq_meter.sv - multi-channel ring-oscillator edge counter with min/max statistics
module pvt_ro_freq_meter #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] osc_in,
    pvt_ro_freq_meter_if.slave bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

    state_t            state;
    logic              arm_cnt;
    logic [GATE_W-1:0] gate_left;
    logic [NCH-1:0]    en_q;
    logic              busy_q;
    logic              done_q;

    logic [NCH-1:0]    sync1, sync2, sync3;
    logic [NCH-1:0]    edge_det;

    logic [CNT_W-1:0]  cnt     [NCH];
    logic [CNT_W-1:0]  res     [NCH];
    logic [CNT_W-1:0]  mn      [NCH];
    logic [CNT_W-1:0]  mx      [NCH];
    logic [CNT_W-1:0]  mn_base [NCH];
    logic [CNT_W-1:0]  mx_base [NCH];
    logic [NCH-1:0]    sat;
    logic [NCH-1:0]    ovf_q;

    assign edge_det = sync2 & ~sync3;

    // Two-flop synchronizer plus a third flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Measurement sequencer: IDLE -> ARM (2 cycles) -> GATE (G cycles) -> LATCH -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            arm_cnt   <= 1'b0;
            gate_left <= '0;
            en_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= ARM;
                        arm_cnt   <= 1'b0;
                        gate_left <= (bus.gate_cycles == '0) ? GATE_W'(1) : bus.gate_cycles;
                        en_q      <= bus.ch_en;
                        busy_q    <= 1'b1;
                    end
                end
                ARM: begin
                    arm_cnt <= 1'b1;
                    if (arm_cnt) state <= GATE;
                end
                GATE: begin
                    if (gate_left == GATE_W'(1)) state <= LATCH;
                    else gate_left <= gate_left - GATE_W'(1);
                end
                LATCH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating per-channel edge counters, cleared while arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            sat <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (state == ARM) begin
                    cnt[i] <= '0;
                    sat[i] <= 1'b0;
                end else if (state == GATE && en_q[i] && edge_det[i]) begin
                    if (cnt[i] == '1) sat[i] <= 1'b1;
                    else cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Statistics seen by LATCH: a coincident clear_stats is applied first
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mn_base[i] = bus.clear_stats ? '1 : mn[i];
            mx_base[i] = bus.clear_stats ? '0 : mx[i];
        end
    end

    // Result, overflow and running min/max registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                res[i] <= '0;
                mn[i]  <= '1;
                mx[i]  <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (state == LATCH && en_q[i]) begin
                    res[i]   <= cnt[i];
                    ovf_q[i] <= sat[i];
                    mn[i]    <= (cnt[i] < mn_base[i]) ? cnt[i] : mn_base[i];
                    mx[i]    <= (cnt[i] > mx_base[i]) ? cnt[i] : mx_base[i];
                end else if (bus.clear_stats) begin
                    mn[i] <= '1;
                    mx[i] <= '0;
                end
            end
        end
    end

    // Readout mux; an out-of-range channel index reads zero
    always_comb begin
        bus.rd_count = '0;
        bus.rd_min   = '0;
        bus.rd_max   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                bus.rd_count = res[i];
                bus.rd_min   = mn[i];
                bus.rd_max   = mx[i];
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_pvt_ro_freq_meter.sv
// tb/tb_pvt_ro_freq_meter.sv - self-checking bench for pvt_ro_freq_meter
module tb_pvt_ro_freq_meter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] osc;
    int         per [4];
    int         cyc = 0;
    int         done_cnt = 0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 4; g++) begin : g_osc
        logic o = 1'b0;
        assign osc[g] = o;
        always begin
            if (per[g] == 0) begin
                o = 1'b0;
                #10;
            end else begin
                #(per[g] * 5);
                o = ~o;
            end
        end
    end

    pvt_ro_freq_meter_if #(.NCH(4), .CNT_W(16), .GATE_W(12)) ifm ();
    pvt_ro_freq_meter_if #(.NCH(3), .CNT_W(8),  .GATE_W(12)) if8 ();

    assign if8.start       = ifm.start;
    assign if8.gate_cycles = ifm.gate_cycles;
    assign if8.ch_en       = ifm.ch_en[2:0];
    assign if8.clear_stats = ifm.clear_stats;
    assign if8.rd_sel      = ifm.rd_sel;

    pvt_ro_freq_meter #(.NCH(4), .CNT_W(16), .GATE_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc), .bus(ifm)
    );
    pvt_ro_freq_meter #(.NCH(3), .CNT_W(8), .GATE_W(12)) dut8 (
        .clk(clk), .rst_n(rst_n), .osc_in(osc[2:0]), .bus(if8)
    );

    always @(negedge clk) if (ifm.done) done_cnt++;

    typedef struct {
        logic [3:0] en;
        int         p [4];
        int         gate;
        int         e [4];
        bit         clr;
    } vec_t;
    vec_t vt [6];

    typedef struct {
        int start_edge;
        int gate_eff;
    } pend_t;
    pend_t sbq [$];

    int       m_res [4], m_min [4], m_max [4];
    int       m_res8 [3];
    logic [3:0] m_ovf16;
    logic [2:0] m_ovf8;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        total++;
        if (act > exp + tol || act + tol < exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic set_vec(input int k, input logic [3:0] en, input int p0, input int p1,
                           input int p2, input int p3, input int gate, input int e0,
                           input int e1, input int e2, input int e3, input bit clr);
        vt[k].en = en;
        vt[k].p[0] = p0; vt[k].p[1] = p1; vt[k].p[2] = p2; vt[k].p[3] = p3;
        vt[k].gate = gate;
        vt[k].e[0] = e0; vt[k].e[1] = e1; vt[k].e[2] = e2; vt[k].e[3] = e3;
        vt[k].clr = clr;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_res[i] = 0; m_min[i] = 16'hFFFF; m_max[i] = 0;
        end
        for (int i = 0; i < 3; i++) m_res8[i] = 0;
        m_ovf16 = '0;
        m_ovf8  = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_min[i] = 16'hFFFF; m_max[i] = 0;
        end
    endtask

    task automatic model_apply(input logic [3:0] en, input int e0, input int e1,
                               input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                m_res[i]   = e[i];
                m_min[i]   = (e[i] < m_min[i]) ? e[i] : m_min[i];
                m_max[i]   = (e[i] > m_max[i]) ? e[i] : m_max[i];
                m_ovf16[i] = 1'b0;
                if (i < 3) begin
                    m_res8[i] = (e[i] > 255) ? 255 : e[i];
                    m_ovf8[i] = (e[i] > 255);
                end
            end
        end
    endtask

    task automatic launch(input int gate, input logic [3:0] en);
        pend_t p;
        @(negedge clk);
        ifm.gate_cycles = 12'(gate);
        ifm.ch_en       = en;
        ifm.start       = 1'b1;
        p.start_edge = cyc + 1;
        p.gate_eff   = (gate == 0) ? 1 : gate;
        sbq.push_back(p);
        @(negedge clk);
        ifm.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int    n = 0;
        pend_t p;
        while (!ifm.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) p = sbq.pop_front();
        if (!ifm.done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", budget);
        end else begin
            chk("done_latency", cyc + 1 - p.start_edge, p.gate_eff + 4, 0);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            ifm.rd_sel = 2'(i);
            @(negedge clk);
            chk($sformatf("%s_count%0d", tag, i), int'(ifm.rd_count), m_res[i], 1);
            chk($sformatf("%s_min%0d", tag, i), int'(ifm.rd_min), m_min[i], 1);
            chk($sformatf("%s_max%0d", tag, i), int'(ifm.rd_max), m_max[i], 1);
            if (i < 3) begin
                chk($sformatf("%s_cnt8_%0d", tag, i), int'(if8.rd_count), m_res8[i], 1);
            end else begin
                chk($sformatf("%s_oor_count", tag), int'(if8.rd_count), 0, 0);
                chk($sformatf("%s_oor_min", tag), int'(if8.rd_min), 0, 0);
                chk($sformatf("%s_oor_max", tag), int'(if8.rd_max), 0, 0);
            end
        end
        chk({tag, "_ovf"}, int'(ifm.ovf), int'(m_ovf16), 0);
        chk({tag, "_ovf8"}, int'(if8.ovf), int'(m_ovf8), 0);
        chk({tag, "_busy"}, int'(ifm.busy), 0, 0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4; i++) per[i] = 0;
        ifm.start = 1'b0;
        ifm.gate_cycles = '0;
        ifm.ch_en = '0;
        ifm.clear_stats = 1'b0;
        ifm.rd_sel = '0;
        model_reset();

        set_vec(0, 4'b0001, 8, 0, 0, 0, 400, 50, 0, 0, 0, 1'b0);
        set_vec(1, 4'b0010, 0, 10, 0, 0, 100, 0, 10, 0, 0, 1'b0);
        set_vec(2, 4'b0010, 0, 5, 0, 0, 100, 0, 20, 0, 0, 1'b1);
        set_vec(3, 4'b1111, 4, 4, 4, 4, 2000, 500, 500, 500, 500, 1'b0);
        set_vec(4, 4'b1111, 4, 4, 4, 4, 40, 10, 10, 10, 10, 1'b0);
        set_vec(5, 4'b1100, 0, 0, 7, 6, 210, 0, 0, 30, 35, 1'b0);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(ifm.busy), 0, 0);
        chk("rst_done", int'(ifm.done), 0, 0);
        chk("rst_count", int'(ifm.rd_count), 0, 0);
        chk("rst_min", int'(ifm.rd_min), 16'hFFFF, 0);
        chk("rst_max", int'(ifm.rd_max), 0, 0);
        chk("rst_ovf", int'(ifm.ovf), 0, 0);
        chk("rst_min8", int'(if8.rd_min), 8'hFF, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven measurements
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) per[i] = vt[k].p[i];
            repeat (60) @(negedge clk);
            launch(vt[k].gate, vt[k].en);
            wait_done(vt[k].gate + 20);
            model_apply(vt[k].en, vt[k].e[0], vt[k].e[1], vt[k].e[2], vt[k].e[3]);
            check_all($sformatf("v%0d", k));
            if (vt[k].clr) begin
                @(negedge clk);
                ifm.clear_stats = 1'b1;
                @(negedge clk);
                ifm.clear_stats = 1'b0;
                model_clear();
                check_all($sformatf("v%0d_clr", k));
            end
        end

        // start re-pulsed while busy is ignored
        for (int i = 0; i < 4; i++) per[i] = 0;
        per[0] = 8;
        repeat (60) @(negedge clk);
        d0 = done_cnt;
        launch(50, 4'b0001);
        repeat (9) @(negedge clk);
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        wait_done(80);
        repeat (80) @(negedge clk);
        chk("restart_single_done", done_cnt - d0, 1, 0);
        model_apply(4'b0001, 6, 0, 0, 0);
        check_all("restart");

        // zero gate length behaves as one cycle
        launch(0, 4'b0001);
        wait_done(20);
        model_apply(4'b0001, 0, 0, 0, 0);
        check_all("gate0");

        // clear_stats coincident with LATCH: clear first, then update
        launch(40, 4'b0001);
        repeat (42) @(negedge clk);
        ifm.clear_stats = 1'b1;
        @(negedge clk);
        ifm.clear_stats = 1'b0;
        wait_done(20);
        model_clear();
        model_apply(4'b0001, 5, 0, 0, 0);
        check_all("clr_latch");

        // reset in the middle of GATE
        ifm.rd_sel = '0;
        d0 = done_cnt;
        launch(300, 4'b0001);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(ifm.busy), 0, 0);
        chk("midrst_done", int'(ifm.done), 0, 0);
        chk("midrst_count", int'(ifm.rd_count), 0, 0);
        chk("midrst_min", int'(ifm.rd_min), 16'hFFFF, 0);
        chk("midrst_max", int'(ifm.rd_max), 0, 0);
        chk("midrst_ovf", int'(ifm.ovf), 0, 0);
        if (sbq.size() != 0) void'(sbq.pop_front());
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0, 0);
        launch(400, 4'b0001);
        wait_done(420);
        model_apply(4'b0001, 50, 0, 0, 0);
        check_all("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
